// File: rtl/decode_exec.sv
// Decode/execute stage of the 8-bit ADDER core: drives pc into fetch, latches the
// returned instruction byte and executes it against an 8-bit accumulator.
module decode_exec #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  instruction,
   output logic [7:0]  pc,
   output logic [7:0]  acc,
   output logic        carry,
   output logic        zero,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] retired
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [7:0]  ir_q, ir_d;
   logic [7:0]  acc_q, acc_d;
   logic        carry_q, carry_d;
   logic        zero_q, zero_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        halted_q, halted_d;
   logic        illegal_q, illegal_d;
   logic [15:0] retired_q, retired_d;

   logic [3:0]  opc_s;
   logic [7:0]  op_s;
   logic [8:0]  sum_s;

   assign opc_s = ir_q[7:4];
   assign op_s  = {4'h0, ir_q[3:0]};

   // Next-state and datapath logic; flags only move on LDI/ADDI/SUBI.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      acc_d       = acc_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      halted_d    = halted_q;
      illegal_d   = illegal_q;
      retired_d   = retired_q;
      sum_s       = {1'b0, acc_q} + {1'b0, op_s};

      case (state_q)
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            ir_d    = instruction;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d   = S_FETCH;
            pc_d      = pc_q + 8'd1;
            retired_d = retired_q + 16'd1;
            case (opc_s)
               4'h0: begin
                  pc_d = pc_q + 8'd1;
               end
               4'h1: begin
                  acc_d  = op_s;
                  zero_d = (op_s == 8'h00);
               end
               4'h2: begin
                  acc_d   = sum_s[7:0];
                  carry_d = sum_s[8];
                  zero_d  = (sum_s[7:0] == 8'h00);
               end
               4'h3: begin
                  acc_d   = acc_q - op_s;
                  carry_d = (acc_q < op_s);
                  zero_d  = (acc_q == op_s);
               end
               4'h4: begin
                  pc_d = op_s;
               end
               4'h5: begin
                  // Uses the flag as left by the previous ALU op.
                  if (zero_q) begin
                     pc_d = op_s;
                  end else begin
                     pc_d = pc_q + 8'd1;
                  end
               end
               4'h7: begin
                  out_data_d  = acc_q;
                  out_valid_d = 1'b1;
               end
               4'hF: begin
                  pc_d     = pc_q;
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end
               default: begin
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // State and output registers; reset clears everything without a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         ir_q        <= 8'h00;
         acc_q       <= 8'h00;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         out_data_q  <= 8'h00;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
         illegal_q   <= 1'b0;
         retired_q   <= 16'h0000;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         acc_q       <= acc_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         halted_q    <= halted_d;
         illegal_q   <= illegal_d;
         retired_q   <= retired_d;
      end
   end

   assign pc        = pc_q;
   assign acc       = acc_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign halted    = halted_q;
   assign illegal   = illegal_q;
   assign retired   = retired_q;

endmodule
